// File: rtl/multdiv_issue_if.sv
// Signal bundle between the execute stage, the multiply/divide unit and the issue controller.
interface multdiv_issue_if;
    // Execute-stage request
    logic        issue_mult;
    logic        issue_div;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic [4:0]  rd;
    // Unit start and operands
    logic        md_ctrl_mult;
    logic        md_ctrl_div;
    logic [31:0] md_a;
    logic [31:0] md_b;
    // Unit response
    logic        md_ready;
    logic [31:0] md_result;
    logic        md_exception;
    // Pipeline control and writeback
    logic        stall;
    logic        wb_en;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        wb_exception;
    logic        timeout;

    // Controller side
    modport master (
        input  issue_mult, issue_div, op_a, op_b, rd,
        input  md_ready, md_result, md_exception,
        output md_ctrl_mult, md_ctrl_div, md_a, md_b,
        output stall, wb_en, wb_rd, wb_data, wb_exception, timeout
    );

    // Execute stage / unit side
    modport slave (
        output issue_mult, issue_div, op_a, op_b, rd,
        output md_ready, md_result, md_exception,
        input  md_ctrl_mult, md_ctrl_div, md_a, md_b,
        input  stall, wb_en, wb_rd, wb_data, wb_exception, timeout
    );
endinterface

// File: rtl/multdiv_issue.sv
// Issue controller for the multicycle multiply/divide unit: capture, start pulse,
// stall until ready (or watchdog abort), then a single-cycle writeback.
module multdiv_issue #(
    parameter int unsigned TIMEOUT = 40,
    parameter int unsigned CNT_W   = 6   // 2**CNT_W must exceed TIMEOUT
) (
    input  logic            clock,
    input  logic            resetn,
    multdiv_issue_if.master md_if
);

    typedef enum logic [1:0] {StIdle, StIssue, StBusy, StDone} state_e;

    localparam logic [CNT_W-1:0] LastCnt = CNT_W'(TIMEOUT - 1);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               md_ctrl_mult_q, md_ctrl_mult_d;
    logic               md_ctrl_div_q, md_ctrl_div_d;
    logic [31:0]        md_a_q, md_a_d;
    logic [31:0]        md_b_q, md_b_d;
    logic               wb_en_q, wb_en_d;
    logic [4:0]         wb_rd_q, wb_rd_d;
    logic [31:0]        wb_data_q, wb_data_d;
    logic               wb_exc_q, wb_exc_d;
    logic               timeout_q, timeout_d;

    // Next-state logic; start pulse and write strobe are registered so each lasts one cycle.
    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        md_ctrl_mult_d = 1'b0;
        md_ctrl_div_d  = 1'b0;
        md_a_d         = md_a_q;
        md_b_d         = md_b_q;
        wb_en_d        = 1'b0;
        wb_rd_d        = wb_rd_q;
        wb_data_d      = wb_data_q;
        wb_exc_d       = wb_exc_q;
        timeout_d      = timeout_q;

        case (state_q)
            StIdle: begin
                if (md_if.issue_mult || md_if.issue_div) begin
                    // MULT wins when both are requested
                    md_ctrl_mult_d = md_if.issue_mult;
                    md_ctrl_div_d  = ~md_if.issue_mult;
                    md_a_d         = md_if.op_a;
                    md_b_d         = md_if.op_b;
                    wb_rd_d        = md_if.rd;
                    state_d        = StIssue;
                end
            end
            StIssue: begin
                cnt_d   = '0;
                state_d = StBusy;
            end
            StBusy: begin
                if (md_if.md_ready) begin
                    wb_data_d = md_if.md_result;
                    wb_exc_d  = md_if.md_exception;
                    timeout_d = 1'b0;
                    wb_en_d   = 1'b1;
                    state_d   = StDone;
                end else if (cnt_q == LastCnt) begin
                    wb_data_d = '0;
                    wb_exc_d  = 1'b1;
                    timeout_d = 1'b1;
                    wb_en_d   = 1'b1;
                    state_d   = StDone;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            state_q        <= StIdle;
            cnt_q          <= '0;
            md_ctrl_mult_q <= 1'b0;
            md_ctrl_div_q  <= 1'b0;
            md_a_q         <= '0;
            md_b_q         <= '0;
            wb_en_q        <= 1'b0;
            wb_rd_q        <= '0;
            wb_data_q      <= '0;
            wb_exc_q       <= 1'b0;
            timeout_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            md_ctrl_mult_q <= md_ctrl_mult_d;
            md_ctrl_div_q  <= md_ctrl_div_d;
            md_a_q         <= md_a_d;
            md_b_q         <= md_b_d;
            wb_en_q        <= wb_en_d;
            wb_rd_q        <= wb_rd_d;
            wb_data_q      <= wb_data_d;
            wb_exc_q       <= wb_exc_d;
            timeout_q      <= timeout_d;
        end
    end

    // Stall covers the capture cycle too; it drops in DONE so the instruction retires.
    always_comb begin
        md_if.stall = ((state_q == StIdle) && (md_if.issue_mult || md_if.issue_div)) ||
                      (state_q == StIssue) || (state_q == StBusy);
    end

    assign md_if.md_ctrl_mult = md_ctrl_mult_q;
    assign md_if.md_ctrl_div  = md_ctrl_div_q;
    assign md_if.md_a         = md_a_q;
    assign md_if.md_b         = md_b_q;
    assign md_if.wb_en        = wb_en_q;
    assign md_if.wb_rd        = wb_rd_q;
    assign md_if.wb_data      = wb_data_q;
    assign md_if.wb_exception = wb_exc_q;
    assign md_if.timeout      = timeout_q;

endmodule

// File: tb/tb_multdiv_issue.sv
// Directed bench for multdiv_issue; outputs sampled on the falling edge.
module tb_multdiv_issue;

    logic clock;
    logic resetn;
    multdiv_issue_if bus ();

    multdiv_issue #(
        .TIMEOUT (40),
        .CNT_W   (6)
    ) u_dut (
        .clock  (clock),
        .resetn (resetn),
        .md_if  (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int total = 0;
    int bad   = 0;

    // Observations gathered by drive_op
    int          r_mult, r_div, r_wb, r_wb_n, r_stall;
    logic        r_ops_bad;
    logic [4:0]  r_rd;
    logic [31:0] r_data;
    logic        r_exc, r_to;

    // Present one request at the coming edge (E0), then run ncyc cycles. Negedge n follows
    // edge E(n-1); md_ready driven at negedge ready_at is sampled at edge E(ready_at).
    task automatic drive_op(input logic m, input logic dv, input logic [31:0] a,
                            input logic [31:0] b, input logic [4:0] r, input int ready_at,
                            input logic [31:0] res, input logic exc, input int ncyc);
        r_mult = 0; r_div = 0; r_wb = 0; r_wb_n = -1; r_stall = 0; r_ops_bad = 1'b0;
        r_rd = '0; r_data = '0; r_exc = 1'b0; r_to = 1'b0;
        bus.issue_mult = m; bus.issue_div = dv;
        bus.op_a = a; bus.op_b = b; bus.rd = r;
        for (int n = 1; n <= ncyc; n++) begin
            @(negedge clock);
            if (n == 1) begin
                bus.issue_mult = 1'b0; bus.issue_div = 1'b0;
                bus.op_a = ~a; bus.op_b = ~b; bus.rd = ~r;
            end
            if (bus.md_ctrl_mult) r_mult++;
            if (bus.md_ctrl_div) r_div++;
            if (bus.stall) r_stall++;
            if (bus.wb_en) begin
                r_wb++;
                if (r_wb_n < 0) begin
                    r_wb_n = n; r_rd = bus.wb_rd; r_data = bus.wb_data;
                    r_exc = bus.wb_exception; r_to = bus.timeout;
                end
            end
            if ((r_wb_n < 0 || r_wb_n == n) && (bus.md_a !== a || bus.md_b !== b))
                r_ops_bad = 1'b1;
            bus.md_ready     = (n == ready_at);
            bus.md_result    = (n == ready_at) ? res : (32'hDEAD_0000 | n);
            bus.md_exception = (n == ready_at) ? exc : 1'b1;
        end
        bus.md_ready = 1'b0;
        bus.md_exception = 1'b0;
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        bus.issue_mult = 1'b0; bus.issue_div = 1'b0;
        bus.op_a = '0; bus.op_b = '0; bus.rd = '0;
        bus.md_ready = 1'b0; bus.md_result = '0; bus.md_exception = 1'b0;
        repeat (2) @(negedge clock);
        total++;
        if ({bus.stall, bus.wb_en, bus.md_ctrl_mult, bus.md_ctrl_div, bus.wb_exception,
             bus.timeout} !== 6'b0) begin
            bad++;
            $display("FAIL reset_ctrl got=%b want=000000", {bus.stall, bus.wb_en,
                     bus.md_ctrl_mult, bus.md_ctrl_div, bus.wb_exception, bus.timeout});
        end
        total++;
        if (bus.md_a !== 32'd0 || bus.md_b !== 32'd0 || bus.wb_rd !== 5'd0 ||
            bus.wb_data !== 32'd0) begin
            bad++;
            $display("FAIL reset_data got a=%h b=%h rd=%h d=%h want all zero",
                     bus.md_a, bus.md_b, bus.wb_rd, bus.wb_data);
        end
        // Stall follows the request combinationally even while reset holds the FSM
        bus.issue_mult = 1'b1;
        @(negedge clock);
        total++;
        if (bus.stall !== 1'b1 || bus.md_ctrl_mult !== 1'b0) begin
            bad++;
            $display("FAIL reset_stall got stall=%b start=%b want stall=1 start=0",
                     bus.stall, bus.md_ctrl_mult);
        end
        bus.issue_mult = 1'b0;
        resetn = 1'b1;
        @(negedge clock);
    endtask

    task automatic test_mult();
        drive_op(1'b1, 1'b0, 32'd7, 32'd6, 5'd3, 35, 32'd42, 1'b0, 40);
        total++;
        if (r_mult !== 1 || r_div !== 0) begin
            bad++;
            $display("FAIL mult_pulse got mult=%0d div=%0d want 1/0", r_mult, r_div);
        end
        total++;
        if (r_ops_bad !== 1'b0) begin
            bad++; $display("FAIL mult_operand_hold got=%b want=0", r_ops_bad);
        end
        total++;
        if (r_stall !== 35) begin
            bad++; $display("FAIL mult_stall_cycles got=%0d want=35", r_stall);
        end
        total++;
        if (r_wb !== 1 || r_wb_n !== 36) begin
            bad++;
            $display("FAIL mult_wb_timing got count=%0d at=%0d want 1 at 36", r_wb, r_wb_n);
        end
        total++;
        if (r_rd !== 5'd3 || r_data !== 32'd42 || r_exc !== 1'b0 || r_to !== 1'b0) begin
            bad++;
            $display("FAIL mult_wb_value got rd=%0d d=%0d exc=%b to=%b want 3/42/0/0",
                     r_rd, r_data, r_exc, r_to);
        end
    endtask

    task automatic test_div_zero();
        drive_op(1'b0, 1'b1, 32'd100, 32'd0, 5'd5, 35, 32'd0, 1'b1, 40);
        total++;
        if (r_div !== 1 || r_mult !== 0) begin
            bad++;
            $display("FAIL div_pulse got div=%0d mult=%0d want 1/0", r_div, r_mult);
        end
        total++;
        if (r_wb !== 1 || r_rd !== 5'd5 || r_data !== 32'd0 || r_exc !== 1'b1 ||
            r_to !== 1'b0) begin
            bad++;
            $display("FAIL div_exception got wb=%0d rd=%0d d=%0d exc=%b to=%b want 1/5/0/1/0",
                     r_wb, r_rd, r_data, r_exc, r_to);
        end
    endtask

    task automatic test_both();
        drive_op(1'b1, 1'b1, 32'd9, 32'd4, 5'd7, 10, 32'h1234, 1'b0, 15);
        total++;
        if (r_mult !== 1 || r_div !== 0) begin
            bad++;
            $display("FAIL both_priority got mult=%0d div=%0d want 1/0", r_mult, r_div);
        end
        total++;
        if (r_wb_n !== 11 || r_data !== 32'h1234 || r_rd !== 5'd7) begin
            bad++;
            $display("FAIL both_wb got at=%0d d=%h rd=%0d want 11/1234/7", r_wb_n, r_data, r_rd);
        end
    endtask

    task automatic test_timeout();
        drive_op(1'b0, 1'b1, 32'd1, 32'd2, 5'd9, 0, 32'd0, 1'b0, 48);
        total++;
        if (r_wb !== 1 || r_wb_n !== 42 || r_stall !== 41) begin
            bad++;
            $display("FAIL timeout_timing got wb=%0d at=%0d stall=%0d want 1/42/41",
                     r_wb, r_wb_n, r_stall);
        end
        total++;
        if (r_to !== 1'b1 || r_exc !== 1'b1 || r_data !== 32'd0 || r_rd !== 5'd9) begin
            bad++;
            $display("FAIL timeout_value got to=%b exc=%b d=%h rd=%0d want 1/1/0/9",
                     r_to, r_exc, r_data, r_rd);
        end
        total++;
        if (bus.stall !== 1'b0) begin
            bad++; $display("FAIL timeout_back_idle got stall=%b want=0", bus.stall);
        end
    endtask

    task automatic test_ready_at_limit();
        drive_op(1'b1, 1'b0, 32'd11, 32'd12, 5'd13, 41, 32'hBEEF, 1'b0, 46);
        total++;
        if (r_wb_n !== 42 || r_to !== 1'b0 || r_exc !== 1'b0 || r_data !== 32'hBEEF) begin
            bad++;
            $display("FAIL ready_at_limit got at=%0d to=%b exc=%b d=%h want 42/0/0/beef",
                     r_wb_n, r_to, r_exc, r_data);
        end
    endtask

    task automatic test_reset_mid_op();
        int mult_n = 0;
        int wb_n   = 0;
        bus.issue_mult = 1'b1; bus.op_a = 32'h11; bus.op_b = 32'h22; bus.rd = 5'd21;
        for (int n = 1; n <= 45; n++) begin
            @(negedge clock);
            if (n == 1) bus.issue_mult = 1'b0;
            if (bus.md_ctrl_mult || bus.md_ctrl_div) mult_n++;
            if (bus.wb_en) wb_n++;
            if (n == 11) begin
                resetn = 1'b0;
                bus.issue_div = 1'b1;
            end
            if (n == 12) begin
                total++;
                if (bus.md_a !== 32'd0 || bus.md_b !== 32'd0 || bus.wb_rd !== 5'd0 ||
                    bus.wb_data !== 32'd0 || bus.wb_exception !== 1'b0 ||
                    bus.timeout !== 1'b0) begin
                    bad++;
                    $display("FAIL midreset_regs got a=%h b=%h rd=%0d d=%h exc=%b to=%b",
                             bus.md_a, bus.md_b, bus.wb_rd, bus.wb_data, bus.wb_exception,
                             bus.timeout);
                end
                total++;
                if (bus.stall !== 1'b1 || bus.md_ctrl_div !== 1'b0) begin
                    bad++;
                    $display("FAIL midreset_stall got stall=%b start=%b want 1/0",
                             bus.stall, bus.md_ctrl_div);
                end
                bus.issue_div = 1'b0;
                resetn = 1'b1;
            end
            bus.md_ready = (n == 34);
            bus.md_result = 32'h5555;
        end
        bus.md_ready = 1'b0;
        total++;
        if (wb_n !== 0 || mult_n !== 1 || bus.stall !== 1'b0) begin
            bad++;
            $display("FAIL midreset_abandon got wb=%0d starts=%0d stall=%b want 0/1/0",
                     wb_n, mult_n, bus.stall);
        end
    endtask

    task automatic test_back_to_back();
        int p_n [2];
        int w_n [2];
        logic [4:0]  w_rd [2];
        logic [31:0] w_d [2];
        int np = 0;
        int nw = 0;
        bus.issue_mult = 1'b1; bus.op_a = 32'd3; bus.op_b = 32'd5; bus.rd = 5'd1;
        for (int n = 1; n <= 80; n++) begin
            @(negedge clock);
            if (bus.md_ctrl_mult) begin
                if (np < 2) p_n[np] = n;
                np++;
            end
            if (bus.wb_en) begin
                if (nw < 2) begin
                    w_n[nw] = n; w_rd[nw] = bus.wb_rd; w_d[nw] = bus.wb_data;
                end
                nw++;
            end
            if (n == 2) begin
                bus.op_a = 32'd4; bus.rd = 5'd2;
            end
            if (n == 38) bus.issue_mult = 1'b0;
            bus.md_ready  = (n == 35) || (n == 72);
            bus.md_result = (n == 35) ? 32'd15 : 32'd20;
        end
        bus.md_ready = 1'b0;
        total++;
        if (np !== 2 || nw !== 2) begin
            bad++; $display("FAIL b2b_counts got starts=%0d wb=%0d want 2/2", np, nw);
        end else begin
            total++;
            if (p_n[0] !== 1 || p_n[1] !== 38) begin
                bad++;
                $display("FAIL b2b_start_timing got %0d,%0d want 1,38", p_n[0], p_n[1]);
            end
            total++;
            if (w_n[0] !== 36 || w_rd[0] !== 5'd1 || w_d[0] !== 32'd15) begin
                bad++;
                $display("FAIL b2b_wb_first got at=%0d rd=%0d d=%0d want 36/1/15",
                         w_n[0], w_rd[0], w_d[0]);
            end
            total++;
            if (w_n[1] !== 73 || w_rd[1] !== 5'd2 || w_d[1] !== 32'd20) begin
                bad++;
                $display("FAIL b2b_wb_second got at=%0d rd=%0d d=%0d want 73/2/20",
                         w_n[1], w_rd[1], w_d[1]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_mult();
        test_div_zero();
        test_both();
        test_timeout();
        test_ready_at_limit();
        test_reset_mid_op();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
